// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_meter
// Purpose  : Measures the period of a slow asynchronous clk_in in clk cycles.
//            Define CLK_METER_HIGH_EN to also report the high time per period.
// Revision : 1.0  initial release
// ============================================================================
module clk_period_meter #(
  parameter int unsigned      WIDTH   = 24,
  parameter logic [WIDTH-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             lost
`ifdef CLK_METER_HIGH_EN
  ,
  output logic [WIDTH-1:0] high_time
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             lost_q, lost_d;

  logic             rise;
  logic             new_result;
  logic [WIDTH-1:0] cnt_inc;

  assign rise    = s2_q & ~s3_q;
  assign cnt_inc = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    lost_d     = lost_q;
    new_result = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          lost_d  = 1'b0;
        end
      end
      ST_MEASURE: begin
        // A rise coinciding with the timeout wins and yields period == TIMEOUT.
        if (rise) begin
          new_result = 1'b1;
        end else if (cnt_inc == TIMEOUT) begin
          state_d = ST_IDLE;
          lost_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = rise ? '0 : ((cnt_q == TIMEOUT) ? cnt_q : cnt_inc);
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (new_result) begin
      period_d  = cnt_inc;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~meas_ready;
    end else if (valid_q & meas_ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= clk_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      lost_q    <= lost_d;
    end
  end

  assign period     = period_q;
  assign meas_valid = valid_q;
  assign overrun    = overrun_q;
  assign lost       = lost_q;

`ifdef CLK_METER_HIGH_EN
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic [WIDTH-1:0] hcnt_inc;

  assign hcnt_inc = hcnt_q + {{(WIDTH-1){1'b0}}, s3_q};

  // hcnt never exceeds cnt, so the same saturation bound keeps it from wrapping.
  always_comb begin
    hcnt_d      = rise ? '0 : ((hcnt_q == TIMEOUT) ? hcnt_q : hcnt_inc);
    high_time_d = new_result ? hcnt_inc : high_time_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q      <= '0;
      high_time_q <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_period_meter
// Purpose  : Directed self-checking bench for clk_period_meter (WIDTH=8, TIMEOUT=100).
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_period_meter;

  logic       clk;
  logic       reset;
  logic       clk_in;
  logic [7:0] period;
  logic       meas_valid;
  logic       meas_ready;
  logic       overrun;
  logic       lost;
`ifdef CLK_METER_HIGH_EN
  logic [7:0] high_time;
`endif

  int   checks = 0;
  int   errors = 0;
  logic seen_v;
  logic seen_l;

  clk_period_meter #(
    .WIDTH   (8),
    .TIMEOUT (8'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_in     (clk_in),
    .period     (period),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .overrun    (overrun),
`ifdef CLK_METER_HIGH_EN
    .high_time  (high_time),
`endif
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    clk_in     = 1'b0;
    meas_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  // Inputs change on the falling edge; a rise driven at negedge N shows its
  // result on the outputs at negedge N+3.
  initial begin
    reset      = 1'b1;
    clk_in     = 1'b0;
    meas_ready = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);
    chk("rst_period", period, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_lost", lost, 0);
`ifdef CLK_METER_HIGH_EN
    chk("rst_high_time", high_time, 0);
`endif

    // Arming: a single rise produces nothing
    clk_in = 1'b1; step(4); clk_in = 1'b0;
    seen_v = 1'b0; seen_l = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (meas_valid) seen_v = 1'b1;
      if (lost) seen_l = 1'b1;
    end
    chk("arm_no_valid", seen_v, 0);
    chk("arm_no_lost", seen_l, 0);

    // Steady 8 high / 8 low
    do_reset();
    meas_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      clk_in = 1'b1; step(3);
      if (r == 0) begin
        chk("steady_arm_valid", meas_valid, 0);
      end else begin
        chk("steady_period", period, 16);
        chk("steady_valid", meas_valid, 1);
`ifdef CLK_METER_HIGH_EN
        chk("steady_high_time", high_time, 8);
`endif
      end
      step(1);
      chk("steady_pulse_end", meas_valid, 0);
      step(4); clk_in = 1'b0; step(8);
    end

    // Backpressure
    do_reset();
    clk_in = 1'b1; step(8); clk_in = 1'b0; step(8);
    clk_in = 1'b1; step(3);
    chk("bp_first_valid", meas_valid, 1);
    chk("bp_first_period", period, 16);
    chk("bp_first_overrun", overrun, 0);
    step(5); clk_in = 1'b0; step(12);
    clk_in = 1'b1; step(3);
    chk("bp_ovr_period", period, 20);
    chk("bp_ovr_valid", meas_valid, 1);
    chk("bp_ovr_flag", overrun, 1);
    step(2); meas_ready = 1'b1; step(1); meas_ready = 1'b0;
    chk("bp_acc_valid", meas_valid, 0);
    chk("bp_acc_overrun", overrun, 0);
    step(2); clk_in = 1'b0; step(8);
    clk_in = 1'b1; step(3);
    chk("bp_r4_valid", meas_valid, 1);
    chk("bp_r4_period", period, 16);
    chk("bp_r4_overrun", overrun, 0);
    step(5); clk_in = 1'b0; step(16);
    clk_in = 1'b1; step(2);
    chk("bp_stable_period", period, 16);
    meas_ready = 1'b1; step(1); meas_ready = 1'b0;
    chk("bp_same_valid", meas_valid, 1);
    chk("bp_same_overrun", overrun, 0);
    chk("bp_same_period", period, 24);
    step(1);
    chk("bp_same_hold", meas_valid, 1);

    // Timeout and recovery
    do_reset();
    meas_ready = 1'b1;
    clk_in = 1'b1; step(8); clk_in = 1'b0; step(8);
    clk_in = 1'b1; step(3);
    chk("to_valid", meas_valid, 1);
    chk("to_period", period, 16);
    step(5); clk_in = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 94; i++) begin
      step(1);
      if (meas_valid) seen_v = 1'b1;
    end
    chk("to_lost_before", lost, 0);
    step(1);
    chk("to_lost_at_100", lost, 1);
    chk("to_no_valid", seen_v, 0);
    step(10);
    clk_in = 1'b1; step(2);
    chk("to_lost_hold", lost, 1);
    step(1);
    chk("to_lost_clear", lost, 0);
    chk("to_rearm_no_valid", meas_valid, 0);
    step(7); clk_in = 1'b0; step(20);
    clk_in = 1'b1; step(3);
    chk("to_rec_valid", meas_valid, 1);
    chk("to_rec_period", period, 30);
    chk("to_rec_lost", lost, 0);
    step(1); clk_in = 1'b0;

    // Reset mid-measurement
    do_reset();
    clk_in = 1'b1; step(8); clk_in = 1'b0; step(8);
    clk_in = 1'b1; step(3);
    chk("rm_pre_valid", meas_valid, 1);
    step(5); clk_in = 1'b0; step(6);
    reset = 1'b1;
    #1;
    chk("rm_period", period, 0);
    chk("rm_valid", meas_valid, 0);
    chk("rm_overrun", overrun, 0);
    chk("rm_lost", lost, 0);
    step(2); reset = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (meas_valid) seen_v = 1'b1;
    end
    chk("rm_no_valid", seen_v, 0);
    clk_in = 1'b1; step(3);
    chk("rm_arm_no_valid", meas_valid, 0);
    step(5); clk_in = 1'b0; step(8);
    clk_in = 1'b1; step(3);
    chk("rm_rearm_valid", meas_valid, 1);
    chk("rm_rearm_period", period, 16);
    step(5); clk_in = 1'b0; step(4);

    // Duty cycle 3 high / 13 low
    do_reset();
    meas_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clk_in = 1'b1; step(3);
      if (r > 0) begin
        chk("duty_period", period, 16);
        chk("duty_valid", meas_valid, 1);
`ifdef CLK_METER_HIGH_EN
        chk("duty_high_time", high_time, 3);
`endif
      end
      clk_in = 1'b0; step(13);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of an asynchronous, slow square-wave input, such as the output of the team's clock divider, in cycles of the fast system clock. It synchronises the input, detects rising edges, and captures the cycle count between successive edges. Each result is presented on a valid/ready interface, with loss-of-signal and overrun indication. It sits on the receive side of a divided or external reference clock, for frequency checking and for feeding status registers.

## Interface

- WIDTH, 24: width of the period counter and result.
- TIMEOUT, 24'hFFFFFF: count at which loss of signal is declared. Legal range 2..2^WIDTH-1.
- clk  in  1: system clock. All logic is on its rising edge.
- reset  in  1: asynchronous, active-high reset.
- clk_in  in  1: measured signal, asynchronous to clk.
- period  out  WIDTH: latest captured period, in clk cycles.
- meas_valid  out  1: period holds an unaccepted measurement.
- meas_ready  in  1: consumer accepts the measurement while meas_valid=1.
- overrun  out  1: at least one measurement was overwritten before acceptance.
- lost  out  1: no rising edge seen for TIMEOUT cycles; level output.
- high_time  out  WIDTH: high cycles within the captured period. Present only with CLK_METER_HIGH_EN.

## Operation

- Synchroniser: a 2-flop chain s1→s2 on clk_in, then a third flop s3.
  - Rise pulse = s2 & ~s3, one cycle wide.
  - Input pulses shorter than about 2 clk cycles may be missed. This is allowed.
- Counter cnt:
  - Cleared to 0 on the rise cycle.
  - Otherwise increments every cycle, saturating at TIMEOUT.
- State machine, two states:
  - IDLE (reset state): waiting for a first rise. On rise, go to MEASURE with cnt<=0 and lost<=0. No result is produced.
  - MEASURE, on rise: period<=cnt+1, meas_valid<=1, cnt<=0, stay in MEASURE.
  - MEASURE, when cnt+1==TIMEOUT with no rise that cycle: go to IDLE and set lost<=1. Rise and timeout in the same cycle count as a rise, so the measurement equals TIMEOUT.
- The first rise after reset or after a timeout only arms the meter. A result needs two rises.
- Handshake:
  - Accept = meas_valid & meas_ready.
  - Accept with no new result: meas_valid<=0, overrun<=0.
  - New result while meas_valid & ~meas_ready: period is overwritten, meas_valid stays 1, overrun<=1.
  - New result in the same cycle as an accept: the new value is loaded, meas_valid stays 1, overrun<=0.
  - period, and high_time when present, are stable while meas_valid=1 and no new result arrives.
- Arithmetic:
  - cnt+1 is computed at WIDTH bits.
  - Saturation at TIMEOUT guarantees it never wraps.
- Reset mid-measurement:
  - Everything returns to IDLE immediately.
  - Any pending result is discarded, with no valid pulse.

## Timing

- Reset values: period=0, meas_valid=0, overrun=0, lost=0, high_time=0, cnt=0, synchroniser flops=0, state IDLE.
- Latency: a clk_in rise that meets setup before clk edge k appears in s2 after edge k+1. The rise pulse is active in the following cycle, and period/meas_valid update at edge k+2.
- A steady input with period P clk cycles (P ≥ 4) reports period=P exactly, ±1 on individual samples due to synchroniser jitter.
- lost rises at the edge where cnt+1 reaches TIMEOUT. It falls at the edge where the next rise is processed.
- meas_ready is sampled only while meas_valid=1. Its value at other times is ignored.

## Configuration

- Macro CLK_METER_HIGH_EN. When defined:
  - A second counter hcnt counts cycles with s3=1 in the current window, from the rise cycle up to the cycle before the next rise.
  - On each result, high_time<=hcnt plus 1 if s3 is high that cycle.
  - hcnt clears together with cnt.
  - high_time updates under the same overwrite and handshake rules as period.
- When not defined: the high_time port, hcnt and the related logic are absent, and all other behaviour is identical.

## Test plan

All scenarios use WIDTH=8 and TIMEOUT=100.

- Reset and arming: after reset release, all outputs are 0. Apply one clk_in rise, then hold clk_in low for 50 cycles. Required: meas_valid stays 0 and lost stays 0.
- Steady clock: clk_in toggles every 8 clk cycles (P=16), with meas_ready=1. Required:
  - From the second rise onward, each result is period=16 with a 1-cycle meas_valid pulse.
  - With the macro, high_time=8.
- Backpressure: P=16 with meas_ready=0 for 40 cycles. Required:
  - The third rise overwrites period and sets overrun=1.
  - Raising meas_ready for 1 cycle (between rises) clears meas_valid and overrun.
  - Accept in the same cycle as a rise: meas_valid stays 1 and overrun=0.
- Timeout: stop clk_in after a valid result. Required:
  - lost=1 exactly 100 cycles after the last rise was processed, with no further meas_valid.
  - The next two rises 30 cycles apart give lost=0 at the first rise and period=30 at the second.
- Reset mid-operation: assert reset 5 cycles before an expected result. Required: no meas_valid, all outputs are 0 within the reset cycle, and the meter re-arms on the next rise.
- Duty cycle (macro on): clk_in high 3 and low 13 (P=16). Required: period=16, high_time=3.
